chan_select_mux: RTL and testbench
==================================

// Module: chan_select_mux
// PURPOSE
// - Parametrised, registered N-to-1 channel multiplexer with valid/ready flow control.
// - Selection mode 1: fixed, software-chosen channel. Selection mode 2: round-robin scan of all valid channels.
// - Sits between N producer streams and one consumer; replaces the fixed 8:1 combinational mux
//   wherever channel data must be arbitrated and held across back-pressure.
// PARAMETERS
// - N_CH   default 8                    number of input channels (>=2)
// - WIDTH  default 8                    data bits per channel
// - SEL_W  default $clog2(N_CH)         channel index width (derived; do not override)
// PORTS
// - clk        in   1            single clock; all logic on rising edge
// - rst        in   1            synchronous, active-high reset
// - mode       in   1            0 = MODE_FIXED, 1 = MODE_RR
// - sel_in     in   SEL_W        channel index used in MODE_FIXED
// - in_data    in   N_CH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
// - in_valid   in   N_CH         per-channel valid
// - in_ready   out  N_CH         per-channel ready (one-hot or zero)
// - out_data   out  WIDTH        registered selected data
// - out_ch     out  SEL_W        index of the channel that produced out_data
// - out_valid  out  1            out_data/out_ch hold a beat
// - out_ready  in   1            consumer accepts beat
// BEHAVIOUR
// - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//   in_ready is held all-zero while rst=1. Reset mid-transfer drops the held beat.
// - load_en = !out_valid || out_ready. The single output register may refill in the same
//   cycle its beat is consumed.
// - Grant g (at most one): in_ready[g] = load_en. Transfer when in_valid[g] && in_ready[g].
//   On transfer, next cycle: out_data=in_data[g], out_ch=g, out_valid=1.
// - Latency: exactly 1 cycle from input handshake to out_valid.
//   Throughput: 1 beat/cycle while out_ready=1.
// - No transfer && out_ready: out_valid->0 next cycle. out_data and out_ch keep last values.
// - No transfer && !out_ready: all outputs hold (stable under back-pressure).
// - MODE_FIXED: g = sel_in.
//   - sel_in >= N_CH is illegal: no grant, in_ready=0, held beat still drains.
//   - in_ready[sel_in] asserts regardless of in_valid.
// - MODE_RR:
//   - g = first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_CH.
//   - No valid channel: no grant, in_ready=0.
//   - In MODE_RR, in_ready depends combinationally on in_valid.
//   - On transfer, rr_ptr = (g+1) mod N_CH (wrap from N_CH-1 to 0). Otherwise rr_ptr holds.
// - rr_ptr is only updated by transfers in MODE_RR. MODE_FIXED leaves it untouched.
// - mode/sel_in are sampled combinationally each cycle. A change takes effect on the next
//   grant; a beat already in the output register is unaffected.
// - No combinational path from out_ready to out_data/out_valid. out_ready does feed in_ready via load_en.
// STRUCTURE
// - Package chan_mux_pkg:
//   - typedef enum logic {MODE_FIXED=1'b0, MODE_RR=1'b1} mux_mode_e
//   - function/localparam helpers for SEL_W
// - Sub-module rr_pick #(N_CH): combinational, in (req[N_CH], ptr[SEL_W]) -> out (gnt_idx, gnt_vld).
//   Rotate-priority search.
// - Top holds: grant select (mode mux), output register, rr_ptr register, in_ready decode.
// - Data path: indexed part-select in_data[g*WIDTH +: WIDTH]. No latches; always_comb/always_ff only.
// TESTING
// - Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0 throughout.
// - Fixed mode: mode=0, sel_in=5, in_data ch5=8'hA5, in_valid=8'hFF, out_ready=1
//   -> in_ready=8'h20; next cycle out_data=A5, out_ch=5, out_valid=1.
// - RR fairness: mode=1, in_valid=8'hFF, out_ready=1 for 10 cycles
//   -> out_ch sequence 0,1,2,...,7,0,1 (wrap checked).
// - RR sparse: in_valid=8'b1000_0100, rr_ptr=3 -> grants 7 then 2 then 7.
//   in_valid=0 -> out_valid falls after drain.
// - Back-pressure: out_valid=1, out_ready=0 for 4 cycles -> out_data/out_ch stable, in_ready=0, rr_ptr unchanged.
//   Release -> refill same cycle.
// - Illegal sel/reset mid-op: N_CH=6, mode=0, sel_in=7 -> in_ready=0.
//   rst during out_valid=1, out_ready=0 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared types and sizing helpers for the channel select multiplexer.
package chan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Index width for n channels; a 2-channel mux still needs one select bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chan_select_mux_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping mod N_CH.
module rr_pick
    import chan_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    int idx;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (req[idx]) begin
                gnt_idx = SEL_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_select_mux.sv
// Registered N-to-1 channel mux with valid/ready handshakes; fixed or round-robin channel choice.
module chan_select_mux
    import chan_mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = sel_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] g;
    logic             g_vld;
    logic             load_en;
    logic             xfer;

    rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    assign load_en = !out_valid || out_ready;

    // Out-of-range fixed selects (only possible when N_CH is not a power of two) grant nothing.
    always_comb begin
        g     = sel_in;
        g_vld = (32'(sel_in) < N_CH);
        if (mux_mode_e'(mode) == MODE_RR) begin
            g     = rr_idx;
            g_vld = rr_vld;
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && g_vld && load_en) in_ready[g] = 1'b1;
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
                out_ch    <= g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && mux_mode_e'(mode) == MODE_RR)
                rr_ptr <= (g == SEL_W'(N_CH - 1)) ? '0 : g + 1'b1;
        end
    end

endmodule

// File: tb/tb_chan_select_mux.sv
// Directed bench for chan_select_mux: expected beats go to a scoreboard queue, a monitor checks them.
module tb_chan_select_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [2:0]  sel_in;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode6;
    logic [2:0]  sel6;
    logic [47:0] data6;
    logic [5:0]  valid6;
    logic [5:0]  ready6;
    logic [7:0]  odata6;
    logic [2:0]  och6;
    logic        ovalid6;
    logic        oready6;

    int vectors = 0;
    int miscmp  = 0;
    logic [10:0] sb[$];   // {ch, data}

    always #5 clk = ~clk;

    chan_select_mux #(.N_CH(8), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel_in(sel_in), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    chan_select_mux #(.N_CH(6), .WIDTH(8)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel_in(sel6), .in_data(data6),
        .in_valid(valid6), .in_ready(ready6), .out_data(odata6), .out_ch(och6),
        .out_valid(ovalid6), .out_ready(oready6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries 8'hA0+i, so channel 5 presents 8'hA5.
    task automatic push(input int ch);
        sb.push_back({3'(ch), 8'(8'hA0 + ch)});
    endtask

    // Monitor: a beat is consumed when out_valid && out_ready at the coming edge.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscmp++;
                $display("FAIL unexpected_beat: got ch %0d data %0h, none expected", out_ch, out_data);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                chk("beat_ch", 32'(out_ch), 32'(e[10:8]));
                chk("beat_data", 32'(out_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 6; i++) data6[i*8 +: 8] = 8'hA0 + 8'(i);
        rst = 1'b1; mode = 1'b0; sel_in = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        mode6 = 1'b0; sel6 = 3'd0; valid6 = '0; oready6 = 1'b1;

        // Reset held two cycles with every channel valid
        repeat (2) begin
            cyc();
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_ch", 32'(out_ch), 32'h0);
        end
        rst = 1'b0;

        // Fixed mode, channel 5
        #1;
        chk("fixed_in_ready", 32'(in_ready), 32'h20);
        push(5);
        cyc();
        in_valid = 8'h00;
        chk("fixed_out_valid", 32'(out_valid), 32'h1);
        cyc();
        chk("fixed_drain", 32'(out_valid), 32'h0);

        // Round robin with all channels valid: 0..7 then wrap to 0,1
        mode = 1'b1; in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(8'h01 << (k % 8)));
            push(k % 8);
            cyc();
        end
        in_valid = 8'h00;
        cyc();
        chk("rr_drain", 32'(out_valid), 32'h0);

        // Move rr_ptr from 2 to 3 via channel 2, then sparse 7,2,7
        in_valid = 8'h04;
        #1;
        chk("rr_ptr_adv", 32'(in_ready), 32'h04);
        push(2);
        cyc();
        in_valid = 8'b1000_0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_sparse", 32'(in_ready), (k == 1) ? 32'h04 : 32'h80);
            push((k == 1) ? 2 : 7);
            cyc();
        end
        in_valid = 8'h00;
        #1;
        chk("rr_none_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("rr_sparse_drain", 32'(out_valid), 32'h0);

        // Back-pressure: channel 0 beat held 4 cycles, rr_ptr stays at 1
        in_valid = 8'hFF;
        push(0);
        cyc();
        out_ready = 1'b0;
        repeat (4) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_ch", 32'(out_ch), 32'h0);
            chk("bp_out_data", 32'(out_data), 32'hA0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_refill_ready", 32'(in_ready), 32'h02);
        push(1);
        cyc();
        in_valid = 8'h00;
        chk("bp_refill_ch", 32'(out_ch), 32'h1);
        cyc();
        cyc();

        // Reset mid-transfer drops a stalled beat
        mode = 1'b0; sel_in = 3'd0; out_ready = 1'b0; in_valid = 8'h01;
        cyc();
        in_valid = 8'h00;
        chk("stall_out_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Six-channel instance: illegal select grants nothing, top legal select works
        sel6 = 3'd7; valid6 = 6'h3F;
        #1;
        chk("illegal_in_ready", 32'(ready6), 32'h0);
        cyc();
        chk("illegal_out_valid", 32'(ovalid6), 32'h0);
        sel6 = 3'd5;
        #1;
        chk("sel5_in_ready", 32'(ready6), 32'h20);
        cyc();
        valid6 = '0;
        chk("sel5_out_ch", 32'(och6), 32'h5);
        chk("sel5_out_data", 32'(odata6), 32'hA5);

        // Bounded wait for the scoreboard to empty
        for (int t = 0; t < 20 && sb.size() != 0; t++) cyc();
        vectors++;
        if (sb.size() != 0) begin
            miscmp++;
            $display("FAIL sb_empty: %0d beats outstanding, 0 expected", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
